lshift_sched: RTL

Sequential scheduler that shares one `lshifter` barrel-shift datapath between two requesters. It arbitrates incoming shift requests and latches the winning operand and shift amount. It drives the shared shifter for one cycle, then holds the registered result behind a valid/ready handshake until the consumer accepts it. It sits between the requesting units and the single `lshifter` instance, which it instantiates internally.

---
 rtl/lshift_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lshift_sched.sv
// lshift_sched: shares one lshifter barrel-shift datapath between two requesters.
//
// A request is accepted in IDLE and its operand, shift amount and requester id are
// latched. The shifter runs from those registers for one SHIFT cycle, and its output
// is registered and presented in HOLD until the consumer takes it.
//
// Configuration macro: LSHIFT_SCHED_RR_EN
//   defined   - round-robin arbitration on a tie, using a 1-bit last-grant register
//   undefined - fixed priority, requester 0 wins every tie
//
// Parameters:
//   data_width - operand/result width (>= 5)
//   shift_len  - shift-amount width (fixed at 3: 1/2/4 shifter stages)
// Ports:
//   clk, rst                                 - clock, async active-high reset
//   req{0,1}_valid/_data/_bits, req{0,1}_ready - requester handshakes
//   res_valid/res_data/res_id, res_ready     - result handshake
//   busy                                     - high whenever not idle

// Three-stage logarithmic left shifter (1, 2, 4). Zeros fill from the LSB.
module lshifter #(
  parameter int unsigned data_width = 8
) (
  input  logic [data_width-1:0] data,
  input  logic [2:0]            bits,
  output logic [data_width-1:0] result
);

  logic [data_width-1:0] stage1;
  logic [data_width-1:0] stage2;

  always_comb begin
    stage1 = bits[0] ? (data << 1)   : data;
    stage2 = bits[1] ? (stage1 << 2) : stage1;
    result = bits[2] ? (stage2 << 4) : stage2;
  end

endmodule

module lshift_sched #(
  parameter int unsigned data_width = 8,
  parameter int unsigned shift_len  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [data_width-1:0] req0_data,
  input  logic [shift_len-1:0]  req0_bits,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [data_width-1:0] req1_data,
  input  logic [shift_len-1:0]  req1_bits,
  output logic                  req1_ready,
  output logic                  res_valid,
  output logic [data_width-1:0] res_data,
  output logic                  res_id,
  input  logic                  res_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e                state_q, state_d;
  logic [data_width-1:0] op_data_q;
  logic [shift_len-1:0]  op_bits_q;
  logic                  op_id_q;
  logic [data_width-1:0] res_data_q;
  logic                  res_id_q;
  logic [data_width-1:0] shift_out;
  logic                  grant;     // requester index favoured this cycle
  logic                  xfer;

`ifdef LSHIFT_SCHED_RR_EN
  logic last_q;

  // Resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (xfer) begin
      last_q <= grant;
    end
  end

  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else begin
      grant = ~req0_valid;
    end
  end
`else
  always_comb begin
    grant = ~req0_valid;
  end
`endif

  always_comb begin
    req0_ready = (state_q == StIdle) & ~grant & req0_valid;
    req1_ready = (state_q == StIdle) &  grant & req1_valid;
    xfer       = req0_ready | req1_ready;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (xfer)      state_d = StShift;
      StShift:                state_d = StHold;
      StHold:  if (res_ready) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_data_q  <= '0;
      op_bits_q  <= '0;
      op_id_q    <= 1'b0;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        op_data_q <= grant ? req1_data : req0_data;
        op_bits_q <= grant ? req1_bits : req0_bits;
        op_id_q   <= grant;
      end
      if (state_q == StShift) begin
        res_data_q <= shift_out;
        res_id_q   <= op_id_q;
      end
    end
  end

  lshifter #(
    .data_width(data_width)
  ) u_lshifter (
    .data  (op_data_q),
    .bits  (op_bits_q),
    .result(shift_out)
  );

  always_comb begin
    res_valid = (state_q == StHold);
    res_data  = res_data_q;
    res_id    = res_id_q;
    busy      = (state_q != StIdle);
  end

endmodule
